// File: rtl/iecdrv_timer_pkg.sv
// iecdrv_timer_pkg: register map, CTRL fields and count-source encodings for the timer bank
package iecdrv_timer_pkg;
  localparam logic [2:0] OFF_CTRL = 3'd4;
  localparam logic [2:0] OFF_ICR = 3'd7;
  localparam int CTRL_START = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_TOGGLE = 2;
  localparam int CTRL_LOAD = 3;
  localparam int CTRL_SRC = 4;
  localparam int ICR_SET = 7;
  typedef enum logic [1:0] {
    SRC_PHI2 = 2'b00,
    SRC_CNT = 2'b01,
    SRC_CHAIN = 2'b10,
    SRC_CHAIN_CNT = 2'b11
  } src_e;
endpackage

// File: rtl/iecdrv_timer_chan.sv
// iecdrv_timer_chan: one down-counting timer channel with latch, control and pulse/toggle output
module iecdrv_timer_chan import iecdrv_timer_pkg::*; #(
  parameter int TIMER_W = 16
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       tick,
  input  logic       wr,
  input  logic [2:0] addr,
  input  logic [7:0] db_in,
  input  logic       cnt_in,
  input  logic       cnt_rise,
  input  logic       chain_in,
  output logic       uf,
  output logic [7:0] rdata,
  output logic       tout
);
  localparam int MSB_BYTE = (TIMER_W - 1) / 8;
  logic [TIMER_W-1:0] latch, latch_nx, cnt;
  logic [31:0] cnt32;
  logic start, oneshot, tmode, tff, pulse, load_pend, evt, ctrl_wr, set_load;
  src_e src;
  // the merged latch feeds reloads so a same-cycle byte write wins
  always_comb begin
    latch_nx = latch;
    for (int i = 0; i < TIMER_W; i++)
      if (wr && addr == 3'(i / 8)) latch_nx[i] = db_in[3'(i % 8)];
  end
  assign evt = src == SRC_PHI2 ? 1'b1 : src == SRC_CNT ? cnt_rise :
               src == SRC_CHAIN ? chain_in : chain_in & cnt_in;
  assign uf = tick & start & evt & (cnt == '0);
  assign ctrl_wr = wr && addr == OFF_CTRL;
  assign set_load = (ctrl_wr && db_in[CTRL_LOAD]) || (wr && addr == 3'(MSB_BYTE) && !start);
  assign cnt32 = 32'(cnt);
  assign rdata = addr == OFF_CTRL ? {2'b00, src, 1'b0, tmode, oneshot, start} :
                 addr < 3'd4 ? cnt32[{addr[1:0], 3'b000} +: 8] : 8'h00;
  assign tout = tmode ? tff : pulse;
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      latch <= '1;
      cnt <= '0;
      start <= 1'b0;
      oneshot <= 1'b0;
      tmode <= 1'b0;
      src <= SRC_PHI2;
      tff <= 1'b0;
      pulse <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      latch <= latch_nx;
      if (tick) pulse <= uf;
      if (uf) tff <= ~tff;
      if (uf && oneshot) start <= 1'b0;
      if (tick && load_pend) cnt <= latch_nx;
      else if (tick && start && evt) cnt <= cnt == '0 ? latch_nx : cnt - TIMER_W'(1);
      if (set_load) load_pend <= 1'b1;
      else if (tick) load_pend <= 1'b0;
      if (ctrl_wr) begin
        start <= db_in[CTRL_START];
        oneshot <= db_in[CTRL_ONESHOT];
        tmode <= db_in[CTRL_TOGGLE];
        src <= src_e'(db_in[CTRL_SRC +: 2]);
        if (db_in[CTRL_START] && !start) tff <= 1'b1;
      end
    end
endmodule

// File: rtl/iecdrv_timer_bank.sv
// iecdrv_timer_bank: bank of chainable timers with bus decode, shared ICR and interrupt output
module iecdrv_timer_bank import iecdrv_timer_pkg::*; #(
  parameter int NUM_TIMERS = 4,
  parameter int TIMER_W = 16
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  phi2_p,
  input  logic                  phi2_n,
  input  logic                  cs_n,
  input  logic                  rw,
  input  logic [5:0]            rs,
  input  logic [7:0]            db_in,
  output logic [7:0]            db_out,
  input  logic                  cnt_in,
  output logic [NUM_TIMERS-1:0] timer_out,
  output logic                  irq_n
);
  logic rd, wr, cnt_prev, cnt_rise, clr_pend;
  logic [2:0] ch, off;
  logic [6:0] pending, mask, uf7;
  logic [7:0] rsel;
  logic [NUM_TIMERS-1:0] uf, chain, wr_ch;
  logic [NUM_TIMERS-1:0][7:0] rdata;
  assign rd = phi2_n & ~cs_n & rw;
  assign wr = phi2_n & ~cs_n & ~rw;
  assign ch = rs[5:3];
  assign off = rs[2:0];
  assign cnt_rise = cnt_in & ~cnt_prev;
  assign chain = NUM_TIMERS'({uf, 1'b0});
  assign uf7 = 7'(uf);
  genvar n;
  for (n = 0; n < NUM_TIMERS; n++) begin : g_chan
    assign wr_ch[n] = wr && ch == 3'(n) && off != OFF_ICR;
    iecdrv_timer_chan #(.TIMER_W(TIMER_W)) u_chan (
      .clk(clk), .res_n(res_n), .tick(phi2_p), .wr(wr_ch[n]), .addr(off),
      .db_in(db_in), .cnt_in(cnt_in), .cnt_rise(cnt_rise), .chain_in(chain[n]),
      .uf(uf[n]), .rdata(rdata[n]), .tout(timer_out[n])
    );
  end
  always_comb begin
    rsel = off == OFF_ICR ? {~irq_n, pending} : 8'h00;
    for (int i = 0; i < NUM_TIMERS; i++)
      if (off != OFF_ICR && ch == 3'(i)) rsel = rdata[i];
  end
  // an ICR read only arms the clear; it lands on the next tick so a coincident underflow survives
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      db_out <= 8'h00;
      pending <= '0;
      mask <= '0;
      irq_n <= 1'b1;
      cnt_prev <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      if (phi2_p) cnt_prev <= cnt_in;
      if (rd) db_out <= rsel;
      if (wr && off == OFF_ICR) mask <= db_in[ICR_SET] ? mask | db_in[6:0] : mask & ~db_in[6:0];
      if (rd && off == OFF_ICR) clr_pend <= 1'b1;
      else if (phi2_p) clr_pend <= 1'b0;
      pending <= (phi2_p && clr_pend ? 7'd0 : pending) | uf7;
      irq_n <= (phi2_p && clr_pend) ? 1'b1 : ~|(pending & mask);
    end
endmodule
